// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: master indices, read-owner encoding and counter sizing shared by the arbiter.
package ram_arbiter_pkg;
   localparam int M_CPU = 0;
   localparam int M_AUX = 1;
   typedef logic [1:0] rd_owner_t;
   localparam rd_owner_t RD_NONE = 2'b00;
   localparam rd_owner_t RD_CPU  = 2'b01;
   localparam rd_owner_t RD_AUX  = 2'b10;
   function automatic int cnt_width(int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction
   function automatic rd_owner_t rd_encode(logic cpu_rd, logic aux_rd);
      return cpu_rd ? RD_CPU : aux_rd ? RD_AUX : RD_NONE;
   endfunction
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive denied cycles; at_max opens the override slot.
module arb_wait_counter
   import ram_arbiter_pkg::*;
#(
   parameter int MAX = 8,
   localparam int W = cnt_width(MAX)
) (
   input  logic clk,
   input  logic reset_b,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   logic [W-1:0] count;
   assign at_max = (count == W'(MAX));
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) count <= '0;
      else if (clr) count <= '0;
      else if (inc && !at_max) count <= count + 1'b1;
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between a fixed-priority CPU port and an auxiliary master
// that is guaranteed a slot after MAX_WAIT consecutive denials.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DSIZE    = 16,
   parameter int ASIZE    = 14,
   parameter int MAX_WAIT = 8
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             m0_req,
   input  logic             m1_req,
   input  logic             m0_rnw,
   input  logic             m1_rnw,
   input  logic [ASIZE-1:0] m0_addr,
   input  logic [ASIZE-1:0] m1_addr,
   input  logic [DSIZE-1:0] m0_din,
   input  logic [DSIZE-1:0] m1_din,
   output logic             m0_gnt,
   output logic             m1_gnt,
   output logic             m0_rvalid,
   output logic             m1_rvalid,
   output logic [DSIZE-1:0] m0_rdata,
   output logic [DSIZE-1:0] m1_rdata,
   output logic             ram_cs_b,
   output logic             ram_rnw,
   output logic [ASIZE-1:0] ram_addr,
   output logic [DSIZE-1:0] ram_din,
   input  logic [DSIZE-1:0] ram_dout
);
   logic at_max, inc;
   rd_owner_t rd_owner;
   arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
      .clk(clk), .reset_b(reset_b), .inc(inc), .clr(!inc), .at_max(at_max)
   );
   // grants are gated by reset so nothing reaches the RAM while it is asserted
   always_comb begin
      m1_gnt   = reset_b && m1_req && (!m0_req || at_max);
      m0_gnt   = reset_b && m0_req && !m1_gnt;
      inc      = m1_req && !m1_gnt;
      ram_cs_b = !(m0_gnt || m1_gnt);
      ram_rnw  = m1_gnt ? m1_rnw  : m0_gnt ? m0_rnw  : 1'b1;
      ram_addr = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
      ram_din  = m1_gnt ? m1_din  : m0_gnt ? m0_din  : '0;
   end
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) rd_owner <= RD_NONE;
      else rd_owner <= rd_encode(m0_gnt && m0_rnw, m1_gnt && m1_rnw);
   end
   assign m0_rvalid = rd_owner[M_CPU];
   assign m1_rvalid = rd_owner[M_AUX];
   assign m0_rdata  = ram_dout;
   assign m1_rdata  = ram_dout;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, directed corner cases and randomized traffic against a reference model.
module tb_ram_arbiter;
   logic clk, reset_b;
   logic m0_req, m1_req, m0_rnw, m1_rnw;
   logic [13:0] m0_addr, m1_addr;
   logic [15:0] m0_din, m1_din;
   logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_cs_b, ram_rnw;
   logic [15:0] m0_rdata, m1_rdata, ram_din, ram_dout;
   logic [13:0] ram_addr;
   logic z_m0_gnt, z_m1_gnt, z_m0_rvalid, z_m1_rvalid, z_cs_b, z_rnw;
   logic [15:0] z_m0_rdata, z_m1_rdata, z_din;
   logic [13:0] z_addr;
   logic [15:0] mem [0:16383];
   logic [15:0] exp_mem [0:16383];
   bit known [0:16383];
   int tests = 0, fails = 0;
   int st;
   logic pv0, pv1, pk, zv0, zv1, lg0, lg1;
   logic [15:0] pd;

   ram_arbiter #(.DSIZE(16), .ASIZE(14), .MAX_WAIT(3)) dut (
      .clk(clk), .reset_b(reset_b), .m0_req(m0_req), .m1_req(m1_req), .m0_rnw(m0_rnw), .m1_rnw(m1_rnw),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_din(m0_din), .m1_din(m1_din), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .ram_cs_b(ram_cs_b), .ram_rnw(ram_rnw), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );
   ram_arbiter #(.DSIZE(16), .ASIZE(14), .MAX_WAIT(0)) dut0 (
      .clk(clk), .reset_b(reset_b), .m0_req(m0_req), .m1_req(m1_req), .m0_rnw(m0_rnw), .m1_rnw(m1_rnw),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_din(m0_din), .m1_din(m1_din), .m0_gnt(z_m0_gnt), .m1_gnt(z_m1_gnt),
      .m0_rvalid(z_m0_rvalid), .m1_rvalid(z_m1_rvalid), .m0_rdata(z_m0_rdata), .m1_rdata(z_m1_rdata),
      .ram_cs_b(z_cs_b), .ram_rnw(z_rnw), .ram_addr(z_addr), .ram_din(z_din), .ram_dout(16'h0000)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_cs_b) begin
         if (ram_rnw) ram_dout <= mem[ram_addr];
         else mem[ram_addr] <= ram_din;
      end
   end

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [30:0] mux(logic g0, logic g1);
      return g1 ? {m1_rnw, m1_addr, m1_din} : g0 ? {m0_rnw, m0_addr, m0_din} : {1'b1, 30'b0};
   endfunction

   task automatic idle();
      m0_req = 0; m1_req = 0; m0_rnw = 1; m1_rnw = 1;
      m0_addr = '0; m1_addr = '0; m0_din = '0; m1_din = '0;
   endtask

   task automatic do_reset();
      idle();
      reset_b = 0;
      repeat (2) @(posedge clk);
      #1 reset_b = 1;
      st = 0; pv0 = 0; pv1 = 0; pk = 0; pd = '0; zv0 = 0; zv1 = 0; lg0 = 0; lg1 = 0;
   endtask

   // model: m1 wins when alone or after MAX denials in a row; reads return one cycle later
   task automatic check_cycle(int max);
      logic e0, e1, f0, f1;
      logic [13:0] a;
      @(negedge clk);
      e1 = m1_req && (!m0_req || st >= max);
      e0 = m0_req && !e1;
      f1 = m1_req;
      f0 = m0_req && !f1;
      chk("m0_gnt", m0_gnt, e0);
      chk("m1_gnt", m1_gnt, e1);
      chk("wait_cnt", 32'(dut.u_wait.count), st);
      chk("m0_rvalid", m0_rvalid, pv0);
      chk("m1_rvalid", m1_rvalid, pv1);
      if (pv0 && pk) chk("m0_rdata", m0_rdata, pd);
      if (pv1 && pk) chk("m1_rdata", m1_rdata, pd);
      chk("ram_cs_b", ram_cs_b, !(e0 || e1));
      chk("ram_mux", {ram_rnw, ram_addr, ram_din}, mux(e0, e1));
      chk("z_m0_gnt", z_m0_gnt, f0);
      chk("z_m1_gnt", z_m1_gnt, f1);
      chk("z_m0_rvalid", z_m0_rvalid, zv0);
      chk("z_m1_rvalid", z_m1_rvalid, zv1);
      chk("z_cs_b", z_cs_b, !(f0 || f1));
      chk("z_mux", {z_rnw, z_addr, z_din}, mux(f0, f1));
      if (zv0 || zv1) chk("z_rdata", {z_m0_rdata, z_m1_rdata}, 0);
      a = e1 ? m1_addr : m0_addr;
      pv0 = e0 && m0_rnw;
      pv1 = e1 && m1_rnw;
      pk = known[a];
      pd = exp_mem[a];
      if ((e0 && !m0_rnw) || (e1 && !m1_rnw)) begin
         exp_mem[a] = e1 ? m1_din : m0_din;
         known[a] = 1;
      end
      st = (m1_req && !e1) ? ((st < max) ? st + 1 : max) : 0;
      zv0 = f0 && m0_rnw;
      zv1 = f1 && m1_rnw;
      lg0 = e0;
      lg1 = e1;
   endtask

   typedef struct {
      bit r0, r1, g0, g1, z0, z1;
      int wc;
   } vec_t;
   vec_t tbl [12];

   initial begin
      tbl = '{'{1,1,1,0,0,1,0}, '{1,1,1,0,0,1,1}, '{1,1,1,0,0,1,2}, '{1,1,0,1,0,1,3},
              '{1,1,1,0,0,1,0}, '{1,0,1,0,1,0,1}, '{0,1,0,1,0,1,0}, '{0,0,0,0,0,0,0},
              '{1,1,1,0,0,1,0}, '{1,1,1,0,0,1,1}, '{1,0,1,0,1,0,2}, '{0,0,0,0,0,0,0}};
      clk = 0;
      reset_b = 1;
      idle();
      #1 reset_b = 0;
      m0_req = 1; m1_req = 1;
      @(negedge clk);
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_cs_b", ram_cs_b, 1);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("rst_wait_cnt", 32'(dut.u_wait.count), 0);
      chk("rst_z_gnt", {z_m0_gnt, z_m1_gnt}, 0);
      next();
      reset_b = 1;
      m0_addr = 14'h0AA; m1_addr = 14'h155;
      // contention with MAX_WAIT 3 and 0, plus withdrawal
      for (int i = 0; i < 12; i++) begin
         m0_req = tbl[i].r0; m1_req = tbl[i].r1;
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), {m0_gnt, m1_gnt}, {tbl[i].g0, tbl[i].g1});
         chk($sformatf("vec%0d_z_gnt", i), {z_m0_gnt, z_m1_gnt}, {tbl[i].z0, tbl[i].z1});
         chk($sformatf("vec%0d_wait_cnt", i), 32'(dut.u_wait.count), tbl[i].wc);
         chk($sformatf("vec%0d_cs_b", i), ram_cs_b, !(tbl[i].g0 || tbl[i].g1));
         chk($sformatf("vec%0d_addr", i), ram_addr, tbl[i].g1 ? 14'h155 : tbl[i].g0 ? 14'h0AA : 14'h0);
         next();
      end
      idle();
      // m1 writes 0xBEEF to 0x0010, then m0 reads it alone
      m1_req = 1; m1_rnw = 0; m1_addr = 14'h0010; m1_din = 16'hBEEF;
      @(negedge clk);
      chk("wr_m1_gnt", m1_gnt, 1);
      chk("wr_mux", {ram_rnw, ram_addr, ram_din}, {1'b0, 14'h0010, 16'hBEEF});
      next();
      idle();
      m0_req = 1; m0_addr = 14'h0010;
      @(negedge clk);
      chk("iso_m0_gnt", m0_gnt, 1);
      chk("iso_cs_b", ram_cs_b, 0);
      chk("iso_wr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      next();
      idle();
      @(negedge clk);
      chk("iso_m0_rvalid", m0_rvalid, 1);
      chk("iso_m0_rdata", m0_rdata, 16'hBEEF);
      chk("iso_m1_rvalid", m1_rvalid, 0);
      next();
      // write 0x1234 to the top address, read it back
      m1_req = 1; m1_rnw = 0; m1_addr = 14'h3FFF; m1_din = 16'h1234;
      @(negedge clk);
      chk("wr2_mux", {ram_cs_b, ram_rnw, ram_addr, ram_din}, {2'b00, 14'h3FFF, 16'h1234});
      next();
      idle();
      m0_req = 1; m0_addr = 14'h3FFF;
      @(negedge clk);
      chk("wr2_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("rd2_m0_gnt", m0_gnt, 1);
      next();
      idle();
      m1_req = 1; m1_addr = 14'h3FFF;
      @(negedge clk);
      chk("rd2_m0_rvalid", m0_rvalid, 1);
      chk("rd2_m0_rdata", m0_rdata, 16'h1234);
      chk("rd3_m1_gnt", m1_gnt, 1);
      next();
      // m0 granted in the same cycle as m1's read return
      idle();
      m0_req = 1; m0_addr = 14'h0010;
      @(negedge clk);
      chk("ovl_m0_gnt", m0_gnt, 1);
      chk("ovl_m1_rvalid", m1_rvalid, 1);
      chk("ovl_m1_rdata", m1_rdata, 16'h1234);
      next();
      idle();
      @(negedge clk);
      chk("ovl_m0_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
      chk("ovl_m0_rdata", m0_rdata, 16'hBEEF);
      next();
      // reset lands between grant and data return
      m0_req = 1; m0_addr = 14'h0010;
      @(negedge clk);
      chk("mr_m0_gnt", m0_gnt, 1);
      #1 reset_b = 0;
      #1 chk("mr_gnt_in_rst", {m0_gnt, m1_gnt}, 0);
      chk("mr_cs_b", ram_cs_b, 1);
      @(negedge clk);
      chk("mr_m0_rvalid", m0_rvalid, 0);
      chk("mr_gnt_held", m0_gnt, 0);
      next();
      reset_b = 1;
      @(negedge clk);
      chk("mr_gnt_after", m0_gnt, 1);
      chk("mr_rvalid_after", m0_rvalid, 0);
      next();
      idle();
      @(negedge clk);
      chk("mr_rdata_after", {m0_rvalid, m0_rdata}, {1'b1, 16'hBEEF});
      next();
      // randomized traffic; a pending request is usually held, sometimes withdrawn
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (!(m0_req && !lg0 && $urandom_range(0, 3) != 0)) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m0_rnw = 1'($urandom_range(0, 1));
            m0_addr = 14'($urandom_range(0, 31));
            m0_din = 16'($urandom);
         end
         if (!(m1_req && !lg1 && $urandom_range(0, 3) != 0)) begin
            m1_req = ($urandom_range(0, 2) != 0);
            m1_rnw = 1'($urandom_range(0, 1));
            m1_addr = 14'($urandom_range(0, 31));
            m1_din = 16'($urandom);
         end
         check_cycle(3);
         next();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port on-chip block RAM between the CPU memory port (master 0) and a second bus master such as a DMA or serial loader (master 1). It sits between the masters and the RAM, in place of a direct CPU-to-RAM connection. Master 0 has fixed priority, and an anti-starvation counter guarantees master 1 a slot. The RAM is clocked on the rising edge of `clk` with lookahead addressing, so read data returns one cycle after the grant.

## Interface

Parameters:
- `DSIZE`, 16, data width.
- `ASIZE`, 14, RAM address width.
- `MAX_WAIT`, 8, consecutive denied cycles after which master 1 overrides master 0; range 0..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_b`  in  1  reset, asynchronous and active-low.
- `m0_req`, `m1_req`  in  1  access request.
- `m0_rnw`, `m1_rnw`  in  1  1 = read, 0 = write.
- `m0_addr`, `m1_addr`  in  ASIZE  word address.
- `m0_din`, `m1_din`  in  DSIZE  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered).
- `m0_rdata`, `m1_rdata`  out  DSIZE  read data, qualified by rvalid.
- `ram_cs_b`  out  1  RAM select, active-low.
- `ram_rnw`  out  1  RAM read/write.
- `ram_addr`  out  ASIZE  RAM address.
- `ram_din`  out  DSIZE  RAM write data.
- `ram_dout`  in  DSIZE  RAM read data, valid the cycle after the access.

## Operation

- **Grant rule.** At most one grant per cycle. A transfer occurs when `mX_req && mX_gnt` at a rising edge.
  - Only one master requesting: that master is granted.
  - Both requesting and `wait_cnt < MAX_WAIT`: m0 is granted.
  - Both requesting and `wait_cnt == MAX_WAIT`: m1 is granted.
  - `MAX_WAIT = 0`: m1 always wins.
- **`wait_cnt`.**
  - Width: `$clog2(MAX_WAIT+1)`, minimum 1.
  - Increments on each edge where `m1_req && !m1_gnt`, saturating at MAX_WAIT.
  - Clears on an m1 grant or when `m1_req` is low.
- **RAM mux.** Driven combinationally from the granted master.
  - `ram_cs_b = !(m0_gnt || m1_gnt)`.
  - `ram_rnw`, `ram_addr` and `ram_din` come from the granted master.
  - When idle: `ram_rnw = 1`, address and data = 0.
- **Read return.**
  - `rd_owner` (2 bits, one-hot) is registered on every edge: bit X = `mX_gnt && mX_rnw`.
  - `mX_rvalid = rd_owner[X]`.
  - `m0_rdata` and `m1_rdata` both equal `ram_dout` and are valid only while the matching rvalid is high.
- **Writes** complete at the granted edge and produce no rvalid.
- **Request protocol.**
  - A master holds req, rnw, addr and din stable until it is granted.
  - A master may withdraw req before it is granted, with no side effects.
  - Back-to-back requests from one master may be granted on every cycle.

## Timing

- **Reset** (`reset_b` low, asynchronous):
  - `wait_cnt = 0`, `rd_owner = 0`.
  - `m0_gnt = m1_gnt = 0` and `ram_cs_b = 1` while reset is asserted.
  - `m0_rvalid = m1_rvalid = 0`.
- **Reset mid-read:** the in-flight rvalid is dropped. No retry is made.
- **Read latency:** grant in cycle N; rvalid and data in cycle N+1.
- **Throughput:** one access per cycle in total.
- **Simultaneous grant of m0 and read return to m1** in the same cycle is legal. The outputs are independent.
- **Starvation bound:** with m0 requesting continuously, m1 is granted within MAX_WAIT+1 cycles of raising req.
- **Counter saturation:** `wait_cnt` never exceeds MAX_WAIT, and never wraps.

## Structure

- Shared package `ram_arbiter_pkg`:
  - Master index constants `M_CPU = 0` and `M_AUX = 1`.
  - The `rd_owner` one-hot encoding.
- One sub-module, `arb_wait_counter`: saturating counter with inputs inc and clr, output at_max, and parameter MAX.
- The top level holds the grant logic, the RAM mux and the `rd_owner` register.

## Test plan

- **Isolated read:** m0 alone reads address 0x0010, RAM holding 0xBEEF → `m0_gnt` high the same cycle; next cycle `m0_rvalid = 1`, `m0_rdata = 0xBEEF`; `m1_rvalid = 0`.
- **Contention:** with MAX_WAIT=3, m0 and m1 request continuously → grant pattern m0, m0, m0, m1, repeating; `wait_cnt` goes 0, 1, 2, 3, then clears.
- **MAX_WAIT=0:** both requesting → m1 is granted every cycle; m0 is granted only when m1 drops req.
- **Write then read:** m1 writes 0x1234 to address 0x3FFF, then m0 reads 0x3FFF → `m0_rdata = 0x1234`; no rvalid during the write cycle.
- **Withdrawal:** m1 requests and is denied for 2 cycles, then drops req → `wait_cnt` returns to 0 and no m1 access reaches the RAM.
- **Mid-read reset:** assert `reset_b` low between the grant and data return of an m0 read → `m0_rvalid` stays 0, `ram_cs_b = 1`, and no grant is given until reset is released.
